// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the stream arbiters.
//   state_e        : arbiter FSM state (ST_IDLE, ST_LOCK)
//   DEFAULT_DATA_W : default beat width
//   next_rr()      : behavioural round-robin pick, meant for arbiters that do
//                    not need the structural rr_pick sub-module
package stream_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam int DEFAULT_DATA_W = 16;

  // Returns the first set bit of req searching ptr+1, ptr+2, ... modulo
  // num_req (num_req <= 16). Returns ptr unchanged when req is empty.
  function automatic logic [3:0] next_rr(input logic [3:0] ptr,
                                         input logic [15:0] req,
                                         input int num_req);
    int c;
    next_rr = ptr;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = 16; k >= 1; k--) begin
      c = (int'(ptr) + k) % num_req;
      if (k <= num_req && req[c]) next_rr = 4'(c);
    end
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle around the stream arbiter.
//   in_valid/in_data/in_last/in_ready : NUM_REQ upstream producer channels,
//                                       requester i on in_data[i*DATA_W +: DATA_W]
//   out_valid/out_data/out_last/out_ready : shared downstream channel
//   grant_id/busy                     : current owner and LOCK indication
// slave  : view of the arbiter itself
// master : view of the surrounding producers/consumer
interface stream_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = stream_rr_arbiter_pkg::DEFAULT_DATA_W
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        in_valid;
  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic [NUM_REQ-1:0]        in_last;
  logic [NUM_REQ-1:0]        in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      out_ready;
  logic [IDW-1:0]            grant_id;
  logic                      busy;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, grant_id, busy
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, grant_id, busy
  );

endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate, priority-encode, un-rotate.
//   req_i     : request vector
//   ptr_i     : index of the last granted requester
//   gnt_idx_o : first requester after ptr_i (wrapping); don't-care if !any_o
//   any_o     : at least one request present
module stream_rr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             start;
  int             off;

  always_comb begin
    // Doubling the vector turns the modulo rotation into a plain slice;
    // start == N (ptr at the top index) selects the unrotated copy.
    dbl   = {req_i, req_i};
    start = int'(ptr_i) + 1;
    rot   = dbl[start +: N];
    off   = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    gnt_idx_o = IW'((start + off) % N);
    any_o     = |req_i;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one downstream stream among
// NUM_REQ producers. A granted requester owns the channel until its last beat
// transfers; priority then rotates past it.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : stream_rr_arbiter_if.slave (upstream channels, downstream channel,
//         grant_id, busy)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; outputs forced low, picking next requester
// ST_LOCK | grant_q owns the channel; zero-latency passthrough
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input logic                clk,
  input logic                rst,
  stream_rr_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_q, grant_d;

  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] in_ready_c;
  logic               out_valid_c;
  logic [DATA_W-1:0]  out_data_c;
  logic               out_last_c;

  stream_rr_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_pick (
    .req_i     (bus.in_valid),
    .ptr_i     (ptr_q),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);  // requester 0 wins the first search
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    in_ready_c  = '0;
    out_valid_c = 1'b0;
    out_data_c  = '0;
    out_last_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        out_valid_c         = bus.in_valid[grant_q];
        out_data_c          = bus.in_data[int'(grant_q)*DATA_W +: DATA_W];
        out_last_c          = bus.in_last[grant_q];
        in_ready_c[grant_q] = bus.out_ready;
        // Pointer only moves on packet completion, so an abandoned or
        // stalled packet never shifts priority.
        if (out_valid_c && bus.out_ready && out_last_c) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_last  = out_last_c;
  assign bus.busy      = (state_q == ST_LOCK);
  assign bus.grant_id  = (state_q == ST_LOCK) ? grant_q : '0;

endmodule
